// File: rtl/mote_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mote_bus_pkg : shared encodings and defaults for the mote bus arbiter
// Revision: 1.0
// ============================================================================
package mote_bus_pkg;

    localparam int NUM_MOTES_DEFAULT    = 4;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3,
        TX_GAP   = 3'd4
    } tx_state_e;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mote_bus_arbiter_uart_tx_8n1.sv
`default_nettype none
// ============================================================================
// uart_tx_8n1 : 8N1 serializer with a one-cycle post-stop gap state
// Revision: 1.0
// ============================================================================
module uart_tx_8n1
    import mote_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       idle,
    output logic       gap
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] c_BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q,  baud_d;
    logic [2:0]        bit_q,   bit_d;
    logic [7:0]        data_q,  data_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    // Baud counter counts down and reloads on zero; each bit lasts CLKS_PER_BIT cycles.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    data_d  = data;
                    baud_d  = c_BAUD_RELOAD;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_q == '0) begin
                    baud_d  = c_BAUD_RELOAD;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_q == '0) begin
                    baud_d = c_BAUD_RELOAD;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_q == '0) begin
                    state_d = TX_GAP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            TX_GAP:  state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        idle = 1'b0;
        gap  = 1'b0;
        case (state_q)
            TX_IDLE:  idle = 1'b1;
            TX_START: tx   = 1'b0;
            TX_DATA:  tx   = data_q[bit_q];
            TX_GAP:   gap  = 1'b1;
            default:  tx   = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mote_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mote_bus_arbiter : round-robin bus owner selection feeding one 8N1 UART
// Revision: 1.0
// ============================================================================
module mote_bus_arbiter
    import mote_bus_pkg::*;
#(
    parameter int NUM_MOTES    = NUM_MOTES_DEFAULT,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MOTES-1:0]   bus_request,
    output logic [NUM_MOTES-1:0]   bus_grant,
    input  logic [NUM_MOTES-1:0]   txd_start,
    input  logic [8*NUM_MOTES-1:0] mote_out,
    output logic                   txd_busy,
    output logic                   rs232_txd
);

    localparam int PTR_W = $clog2(NUM_MOTES);
    localparam logic [PTR_W-1:0]     c_LAST_IDX  = PTR_W'(NUM_MOTES - 1);
    localparam logic [PTR_W:0]       c_NUM_WIDE  = (PTR_W + 1)'(NUM_MOTES);
    localparam logic [NUM_MOTES-1:0] c_GRANT_ONE = NUM_MOTES'(1);

    arb_state_e           arb_state_q, arb_state_d;
    logic [PTR_W-1:0]     owner_q,     owner_d;
    logic [PTR_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [NUM_MOTES-1:0] grant_q,     grant_d;

    logic                 w_pick_valid;
    logic [PTR_W-1:0]     w_pick_idx;
    logic [PTR_W:0]       w_cand_sum;
    logic [PTR_W-1:0]     w_cand;
    logic [7:0]           w_owner_byte;
    logic                 w_start;
    logic                 w_tx_idle;
    logic                 w_tx_gap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arb_state_q <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
        end else begin
            arb_state_q <= arb_state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
        end
    end

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_cand_sum   = '0;
        w_cand       = '0;
        for (int i = NUM_MOTES - 1; i >= 0; i--) begin
            w_cand_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
            if (w_cand_sum >= c_NUM_WIDE) begin
                w_cand_sum = w_cand_sum - c_NUM_WIDE;
            end
            w_cand = w_cand_sum[PTR_W-1:0];
            if (bus_request[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    // A byte accepted in the same cycle the request falls keeps the owner until it drains.
    always_comb begin
        arb_state_d = arb_state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        case (arb_state_q)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    owner_d     = w_pick_idx;
                    grant_d     = c_GRANT_ONE << w_pick_idx;
                    arb_state_d = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                if (!bus_request[owner_q] && w_tx_idle && !w_start) begin
                    grant_d     = '0;
                    rr_ptr_d    = (owner_q == c_LAST_IDX) ? '0 : owner_q + 1'b1;
                    arb_state_d = ARB_IDLE;
                end
            end
            default: arb_state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus_grant    = grant_q;
        w_owner_byte = mote_out[{owner_q, 3'b000} +: 8];
        w_start      = (arb_state_q == ARB_OWNED) && txd_start[owner_q] && w_tx_idle;
        txd_busy     = !(w_tx_idle || w_tx_gap) || w_start;
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clock (clock),
        .reset (reset),
        .start (w_start),
        .data  (w_owner_byte),
        .tx    (rs232_txd),
        .idle  (w_tx_idle),
        .gap   (w_tx_gap)
    );

endmodule
`default_nettype wire

// File: tb/tb_mote_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mote_bus_arbiter : directed self-checking bench for mote_bus_arbiter
// Revision: 1.0
// ============================================================================
module tb_mote_bus_arbiter;

    localparam int NM    = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NM-1:0]   bus_request = '0;
    logic [NM-1:0]   txd_start   = '0;
    logic [8*NM-1:0] mote_out    = '0;
    logic [NM-1:0]   bus_grant;
    logic            txd_busy;
    logic            rs232_txd;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    mote_bus_arbiter #(
        .NUM_MOTES    (NM),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus_request (bus_request),
        .bus_grant   (bus_grant),
        .txd_start   (txd_start),
        .mote_out    (mote_out),
        .txd_busy    (txd_busy),
        .rs232_txd   (rs232_txd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Waits for a start bit, then samples each bit in its middle; returns at mid-stop.
    task automatic capture_frame(output logic [7:0] b, output logic ok, output int t0);
        int n;
        b  = '0;
        ok = 1'b0;
        t0 = 0;
        n  = 0;
        while (rs232_txd !== 1'b0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (rs232_txd !== 1'b0) return;
        t0 = cyc;
        ok = 1'b1;
        repeat (CPB / 2) @(negedge clock);
        if (rs232_txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            b[i] = rs232_txd;
        end
        repeat (CPB) @(negedge clock);
        if (rs232_txd !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", bus_grant); end
        checks++; if (rs232_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", rs232_txd); end
        checks++; if (txd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", txd_busy); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_simultaneous();
        bus_request = 4'b1010;
        @(negedge clock);
        checks++; if (bus_grant !== 4'b0010) begin errors++; $display("FAIL simult_first: got %b expected 0010", bus_grant); end
        repeat (3) @(negedge clock);
        checks++; if (bus_grant !== 4'b0010) begin errors++; $display("FAIL simult_hold: got %b expected 0010", bus_grant); end
        bus_request[1] = 1'b0;
        @(negedge clock);
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL simult_gap: got %b expected 0000", bus_grant); end
        @(negedge clock);
        checks++; if (bus_grant !== 4'b1000) begin errors++; $display("FAIL simult_second: got %b expected 1000", bus_grant); end
        bus_request[3] = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL simult_release: got %b expected 0000", bus_grant); end
    endtask

    task automatic test_single();
        logic [9:0] frame;
        frame = {1'b1, 8'h61, 1'b0};
        bus_request[0] = 1'b1;
        mote_out[7:0]  = 8'h61;
        @(negedge clock);
        checks++; if (bus_grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", bus_grant); end
        checks++; if (txd_busy !== 1'b0) begin errors++; $display("FAIL single_busy_pre: got %b expected 0", txd_busy); end
        txd_start[0] = 1'b1;
        #1;
        checks++; if (txd_busy !== 1'b1) begin errors++; $display("FAIL single_busy_accept: got %b expected 1", txd_busy); end
        for (int rel = 0; rel < FRAME; rel++) begin
            @(negedge clock);
            if (rel == 0) txd_start[0] = 1'b0;
            checks++; if (rs232_txd !== frame[rel / CPB]) begin errors++; $display("FAIL single_bit cycle %0d: got %b expected %b", rel, rs232_txd, frame[rel / CPB]); end
            checks++; if (txd_busy !== 1'b1) begin errors++; $display("FAIL single_busy_frame cycle %0d: got %b expected 1", rel, txd_busy); end
        end
        @(negedge clock);
        checks++; if (txd_busy !== 1'b0 || rs232_txd !== 1'b1) begin errors++; $display("FAIL single_gap: busy=%b txd=%b expected busy=0 txd=1", txd_busy, rs232_txd); end
        bus_request[0] = 1'b0;
        @(negedge clock);
        checks++; if (bus_grant !== 4'b0001) begin errors++; $display("FAIL single_hold_idle: got %b expected 0001", bus_grant); end
        @(negedge clock);
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b expected 0000", bus_grant); end
    endtask

    task automatic test_stream();
        logic [7:0] bytes [0:2];
        logic [7:0] got   [0:2];
        logic       okf   [0:2];
        int         t     [0:2];
        int         lowcnt;
        int         n;
        logic       extra;
        bytes[0] = 8'h61; bytes[1] = 8'h62; bytes[2] = 8'h63;
        lowcnt = 0;
        bus_request[0] = 1'b1;
        n = 0;
        while (bus_grant !== 4'b0001 && n < 8) begin @(negedge clock); n++; end
        checks++; if (bus_grant !== 4'b0001) begin errors++; $display("FAIL stream_grant: got %b expected 0001", bus_grant); end
        mote_out[7:0] = bytes[0];
        txd_start[0]  = 1'b1;
        fork
            begin : mote_model
                int   ptr;
                logic prev, b, pend;
                ptr = 0; prev = 1'b0; pend = 1'b0;
                for (int k = 0; k < 400; k++) begin
                    @(negedge clock);
                    if (pend) begin
                        ptr++;
                        pend = 1'b0;
                        if (ptr == 3) txd_start[0] = 1'b0;
                        else          mote_out[7:0] = bytes[ptr];
                    end
                    b = txd_busy;
                    if (b && !prev) pend = 1'b1;
                    if (!b && (ptr == 1 || ptr == 2)) lowcnt++;
                    prev = b;
                    if (ptr == 3 && !b) begin
                        bus_request[0] = 1'b0;
                        break;
                    end
                end
            end
            begin : frame_grabber
                for (int f = 0; f < 3; f++) capture_frame(got[f], okf[f], t[f]);
            end
        join
        for (int f = 0; f < 3; f++) begin
            checks++; if (okf[f] !== 1'b1 || got[f] !== bytes[f]) begin errors++; $display("FAIL stream_byte %0d: got %h framing_ok=%b expected %h", f, got[f], okf[f], bytes[f]); end
        end
        checks++; if (t[1] - t[0] != FRAME + 2) begin errors++; $display("FAIL stream_spacing01: got %0d expected %0d", t[1] - t[0], FRAME + 2); end
        checks++; if (t[2] - t[1] != FRAME + 2) begin errors++; $display("FAIL stream_spacing12: got %0d expected %0d", t[2] - t[1], FRAME + 2); end
        checks++; if (lowcnt != 2) begin errors++; $display("FAIL stream_gap_cycles: got %0d expected 2", lowcnt); end
        n = 0;
        while (bus_grant !== 4'b0000 && n < 6) begin @(negedge clock); n++; end
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL stream_release: got %b expected 0000", bus_grant); end
        extra = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (rs232_txd !== 1'b1) extra = 1'b1;
        end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL stream_no_fourth: got extra frame=%b expected 0", extra); end
    endtask

    task automatic test_nongranted();
        logic [7:0] got;
        logic       ok, txd_bad;
        int         t0, n;
        txd_bad = 1'b0;
        bus_request[0]  = 1'b1;
        mote_out[23:16] = 8'hFF;
        n = 0;
        while (bus_grant !== 4'b0001 && n < 8) begin @(negedge clock); n++; end
        checks++; if (bus_grant !== 4'b0001) begin errors++; $display("FAIL nongrant_grant: got %b expected 0001", bus_grant); end
        fork
            begin : toggler
                for (int k = 0; k < 60; k++) begin
                    @(negedge clock);
                    txd_start[2] = ~txd_start[2];
                end
            end
            begin : owner
                repeat (3) begin
                    @(negedge clock);
                    #1;
                    if (txd_busy !== 1'b0) txd_bad = 1'b1;
                    if (rs232_txd !== 1'b1) txd_bad = 1'b1;
                end
                mote_out[7:0] = 8'h5A;
                txd_start[0]  = 1'b1;
                @(negedge clock);
                txd_start[0]  = 1'b0;
                capture_frame(got, ok, t0);
            end
        join
        checks++; if (txd_bad !== 1'b0) begin errors++; $display("FAIL nongrant_idle_quiet: got disturbed=%b expected 0", txd_bad); end
        checks++; if (ok !== 1'b1 || got !== 8'h5A) begin errors++; $display("FAIL nongrant_byte: got %h framing_ok=%b expected 5a", got, ok); end
        txd_start[2] = 1'b1;
        #1;
        checks++; if (txd_busy !== 1'b0 || rs232_txd !== 1'b1) begin errors++; $display("FAIL nongrant_after: busy=%b txd=%b expected busy=0 txd=1", txd_busy, rs232_txd); end
        txd_start[2]    = 1'b0;
        mote_out[23:16] = 8'h00;
        bus_request[0]  = 1'b0;
        n = 0;
        while (bus_grant !== 4'b0000 && n < 6) begin @(negedge clock); n++; end
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL nongrant_release: got %b expected 0000", bus_grant); end
    endtask

    task automatic test_drop_mid_frame();
        logic [7:0] got;
        logic       ok;
        int         t0, n;
        bus_request[0] = 1'b1;
        n = 0;
        while (bus_grant !== 4'b0001 && n < 8) begin @(negedge clock); n++; end
        mote_out[7:0] = 8'hA5;
        txd_start[0]  = 1'b1;
        @(negedge clock);
        txd_start[0]  = 1'b0;
        fork
            capture_frame(got, ok, t0);
            begin
                repeat (10) @(negedge clock);
                bus_request[0] = 1'b0;
            end
        join
        checks++; if (ok !== 1'b1 || got !== 8'hA5) begin errors++; $display("FAIL drop_byte: got %h framing_ok=%b expected a5", got, ok); end
        checks++; if (bus_grant !== 4'b0001) begin errors++; $display("FAIL drop_hold_stop: got %b expected 0001", bus_grant); end
        repeat (2) @(negedge clock);
        checks++; if (bus_grant !== 4'b0001 || txd_busy !== 1'b0) begin errors++; $display("FAIL drop_hold_gap: grant=%b busy=%b expected 0001 0", bus_grant, txd_busy); end
        @(negedge clock);
        checks++; if (bus_grant !== 4'b0001) begin errors++; $display("FAIL drop_hold_idle: got %b expected 0001", bus_grant); end
        @(negedge clock);
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL drop_release: got %b expected 0000", bus_grant); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        logic       ok;
        int         t0, n;
        bus_request[0] = 1'b1;
        n = 0;
        while (bus_grant !== 4'b0001 && n < 8) begin @(negedge clock); n++; end
        mote_out[7:0] = 8'h00;
        txd_start[0]  = 1'b1;
        @(negedge clock);
        repeat (21) @(negedge clock);
        checks++; if (rs232_txd !== 1'b0) begin errors++; $display("FAIL rst_pre_bit4: got %b expected 0", rs232_txd); end
        reset = 1'b1;
        #1;
        checks++; if (rs232_txd !== 1'b1) begin errors++; $display("FAIL rst_txd: got %b expected 1", rs232_txd); end
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b expected 0000", bus_grant); end
        checks++; if (txd_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", txd_busy); end
        @(negedge clock);
        bus_request = '0;
        txd_start   = '0;
        mote_out    = '0;
        reset       = 1'b0;
        @(negedge clock);
        bus_request = 4'b1001;
        @(negedge clock);
        checks++; if (bus_grant !== 4'b0001) begin errors++; $display("FAIL rst_rr_restart: got %b expected 0001", bus_grant); end
        mote_out[7:0] = 8'h3C;
        txd_start[0]  = 1'b1;
        @(negedge clock);
        txd_start[0]  = 1'b0;
        capture_frame(got, ok, t0);
        checks++; if (ok !== 1'b1 || got !== 8'h3C) begin errors++; $display("FAIL rst_post_byte: got %h framing_ok=%b expected 3c", got, ok); end
        bus_request = '0;
        n = 0;
        while (bus_grant !== 4'b0000 && n < 10) begin @(negedge clock); n++; end
        checks++; if (bus_grant !== 4'b0000) begin errors++; $display("FAIL rst_final_release: got %b expected 0000", bus_grant); end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single();
        test_stream();
        test_nongranted();
        test_drop_mid_frame();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
